// File: rtl/arc4_ct_writer_if.sv
// Handshake/bus bundle for arc4_ct_writer: start/length, pt and ks
// streams, and the CT memory write port.
interface arc4_ct_writer_if;
    logic       en;
    logic       rdy;
    logic [7:0] len;
    logic       pt_valid;
    logic       pt_ready;
    logic [7:0] pt_data;
    logic       ks_valid;
    logic       ks_ready;
    logic [7:0] ks_data;
    logic [7:0] ct_addr;
    logic [7:0] ct_wrdata;
    logic       ct_wren;
    logic       done;

    modport master (
        output en, len, pt_valid, pt_data, ks_valid, ks_data,
        input  rdy, pt_ready, ks_ready, ct_addr, ct_wrdata, ct_wren, done
    );

    modport slave (
        input  en, len, pt_valid, pt_data, ks_valid, ks_data,
        output rdy, pt_ready, ks_ready, ct_addr, ct_wrdata, ct_wren, done
    );
endinterface

// File: rtl/arc4_ct_writer.sv
// Writes length header then pt^ks bytes into a 256x8 CT memory.
// Optional trailing XOR checksum byte: define ARC4_CT_CHECKSUM_EN.
module arc4_ct_writer #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    arc4_ct_writer_if.slave  io
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_STREAM,
`ifdef ARC4_CT_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t     r_state, w_state;
    logic [7:0] r_len, w_len;
    logic [7:0] r_k, w_k;
    logic [7:0] r_addr, w_addr;
    logic [7:0] r_data, w_data;
    logic       r_wren, w_wren;
    logic       r_done, w_done;
    logic       w_hs;
`ifdef ARC4_CT_CHECKSUM_EN
    logic [7:0] r_csum, w_csum;
`endif

    // Both streams move together; neither is consumed alone.
    assign w_hs        = (r_state == S_STREAM) & io.pt_valid & io.ks_valid;
    assign io.rdy      = (r_state == S_IDLE);
    assign io.pt_ready = w_hs;
    assign io.ks_ready = w_hs;
    assign io.ct_addr   = r_addr;
    assign io.ct_wrdata = r_data;
    assign io.ct_wren   = r_wren;
    assign io.done      = r_done;

    always_comb begin
        w_state = r_state;
        w_len   = r_len;
        w_k     = r_k;
        w_addr  = r_addr;
        w_data  = r_data;
        w_wren  = 1'b0;
        w_done  = 1'b0;
`ifdef ARC4_CT_CHECKSUM_EN
        w_csum  = r_csum;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (io.en) begin
                    w_len   = io.len;
                    w_k     = 8'h00;
                    w_state = S_HDR;
`ifdef ARC4_CT_CHECKSUM_EN
                    w_csum  = 8'h00;
`endif
                end
            end
            S_HDR: begin
                w_wren = 1'b1;
                w_addr = BASE_ADDR;
                w_data = r_len;
                if (r_len == 8'h00) begin
`ifdef ARC4_CT_CHECKSUM_EN
                    w_state = S_CSUM;
`else
                    w_state = S_FIN;
                    w_done  = 1'b1;
`endif
                end else begin
                    w_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    w_k    = r_k + 8'd1;
                    w_addr = BASE_ADDR + w_k;
                    w_data = io.pt_data ^ io.ks_data;
                    w_wren = 1'b1;
`ifdef ARC4_CT_CHECKSUM_EN
                    w_csum = r_csum ^ w_data;
`endif
                    if (w_k == r_len) begin
`ifdef ARC4_CT_CHECKSUM_EN
                        w_state = S_CSUM;
`else
                        w_state = S_FIN;
                        w_done  = 1'b1;
`endif
                    end
                end
            end
`ifdef ARC4_CT_CHECKSUM_EN
            S_CSUM: begin
                w_wren  = 1'b1;
                w_addr  = BASE_ADDR + r_len + 8'd1;
                w_data  = r_csum;
                w_done  = 1'b1;
                w_state = S_FIN;
            end
`endif
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= 8'h00;
            r_k     <= 8'h00;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
            r_wren  <= 1'b0;
            r_done  <= 1'b0;
`ifdef ARC4_CT_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
        end else begin
            r_state <= w_state;
            r_len   <= w_len;
            r_k     <= w_k;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_wren  <= w_wren;
            r_done  <= w_done;
`ifdef ARC4_CT_CHECKSUM_EN
            r_csum  <= w_csum;
`endif
        end
    end
endmodule

// File: doc/arc4_ct_writer.md
Name: arc4_ct_writer

Overview:
- Producer side of the ciphertext memory that the ARC4 decryptor reads.
- Latches a message length, joins a plaintext byte stream with a keystream byte stream, and writes ct = pt XOR ks into a 256x8 CT memory in the length-prefixed layout: header byte = length, followed by the ciphertext bytes.
- Used to build encrypted test images and as the encrypt path that pairs with the decrypt path.

Parameters:
- BASE_ADDR, 8'h00: CT memory address of the length header. All addresses are computed modulo 256.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  start pulse; sampled only while rdy=1
- rdy  output  1  high when idle and able to accept en
- len  input  8  message length in bytes (0..255); latched when en is accepted
- pt_valid  input  1  plaintext byte available
- pt_ready  output  1  plaintext byte consumed this cycle
- pt_data  input  8  plaintext byte
- ks_valid  input  1  keystream byte available
- ks_ready  output  1  keystream byte consumed this cycle
- ks_data  input  8  keystream byte
- ct_addr  output  8  CT memory write address
- ct_wrdata  output  8  CT memory write data
- ct_wren  output  1  CT memory write enable; one-cycle pulse per byte
- done  output  1  one-cycle pulse marking completion

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state IDLE; rdy=1
  - ct_wren=0, ct_addr=0, ct_wrdata=0
  - done=0, pt_ready=0, ks_ready=0
  - internal counter=0
- Reset takes priority over every other event, including mid-message. Any in-flight byte is dropped and no further writes occur.
- ct_addr, ct_wrdata, ct_wren and done are registered outputs. rdy, pt_ready and ks_ready are combinational from state and the valid inputs.
- States: IDLE -> HDR -> STREAM -> FIN -> IDLE.
  - IDLE: rdy=1. en=1 at an edge latches len, clears counter k=0, and goes to HDR. en while rdy=0 is ignored.
  - HDR: one cycle. Registers a write of (BASE_ADDR, len). That write is visible in the following cycle, so the header write appears 2 cycles after the en cycle.
    - len=0: go to FIN.
    - Otherwise: go to STREAM.
  - STREAM: joint handshake.
    - pt_ready = ks_ready = pt_valid & ks_valid. Neither stream is consumed alone.
    - On a handshake edge: k increments, and a write of (BASE_ADDR+k, pt_data ^ ks_data) is registered for the next cycle.
    - Throughput is one byte per cycle.
    - With no handshake, ct_wren=0 and the outputs hold their address/data.
    - The handshake with k reaching len goes to FIN.
  - FIN: done=1 for exactly one cycle, coincident with the last write being visible. Then return to IDLE; rdy=1 in the next cycle.
- The header write and the last data write never collide.
- Addresses wrap: BASE_ADDR+k is taken mod 256, with no error flag.
- pt_ready and ks_ready are 0 outside STREAM.
- Valid held high outside STREAM is not consumed.

Optional Feature:
- Macro: ARC4_CT_CHECKSUM_EN.
- When defined: FIN is preceded by a CSUM state.
  - An 8-bit running XOR of all written ciphertext bytes is kept; it starts at 0 and does not include the header.
  - CSUM registers a write of (BASE_ADDR+len+1 mod 256, checksum).
  - done coincides with the checksum write instead of the last data write.
  - With len=0 the checksum written is 00.
- When undefined: no CSUM state, no checksum register, and no extra write.

Test Plan:
- len=3, pt=41,42,43, ks=10,20,30, both streams always valid, en at cycle 0:
  - ct_wren high at cycles 2,3,4,5 writing (00,03),(01,51),(02,62),(03,73).
  - done at cycle 5; rdy=1 at cycle 6.
  - With ARC4_CT_CHECKSUM_EN: an additional write (04,40), with done moving to that cycle.
- Stall: len=2, ks_valid low for 5 cycles after the header while pt_valid=1:
  - pt_ready=ks_ready=0 and ct_wren=0 throughout the stall.
  - The bytes are then written on consecutive cycles once ks_valid rises.
- len=0:
  - A single write (BASE_ADDR,00).
  - done in the same cycle as that write; pt_ready is never asserted.
- BASE_ADDR=FE, len=3, pt=00,00,00, ks=AA,BB,CC: writes (FE,03),(FF,AA),(00,BB),(01,CC), confirming wrap-around.
- en pulsed again during STREAM: ignored, with no change to the write sequence or the latched len.
- rst asserted after the second data write of a len=5 message:
  - Next cycle: rdy=1, ct_wren=0, done=0.
  - A new en then restarts cleanly with a header write.
